line_fill_engine: RTL
=====================

// Module: line_fill_engine
// PURPOSE
//  Memory-side miss engine feeding the cache's 256-bit refill input (dataBlock).
//  - On a miss it first drains the evicted line from the victim buffer to memory, if one is present.
//  - It then fetches the missing line as 8 x 32-bit beats, assembles it, and pulses fillValid.
//  - Sits between the cache/victim buffer and a simple 32-bit single-beat memory port.
// PARAMETERS
//  LINE_W   256  line width in bits
//  BEAT_W   32   memory beat width; BEATS = LINE_W/BEAT_W = 8
//  TIMEOUT  64   max cycles in RD_WAIT before abort (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk          in   1    clock, rising edge
//  reset        in   1    synchronous, active-high
//  missReq      in   1    miss request; sampled only in IDLE
//  missAddr     in   27   line address of miss (pa[31:5])
//  victimValid  in   1    victim buffer holds a line to write back
//  victimAddr   in   27   line address of victim
//  victimBlock  in   256  victim line data
//  busy         out  1    high whenever FSM != IDLE
//  victimAck    out  1    1-cycle pulse: last victim beat accepted
//  fillValid    out  1    1-cycle pulse: dataBlock holds complete line
//  dataBlock    out  256  assembled refill line (to cache write mux)
//  fillErr      out  1    1-cycle pulse: read timeout abort (0 without MEM_TIMEOUT_EN)
//  memReq       out  1    beat request
//  memWe        out  1    1 = write beat, 0 = read beat
//  memAddr      out  32   byte address {line, beat[2:0], 2'b00}
//  memWdata     out  32   write data
//  memGnt       in   1    beat accepted when memReq & memGnt
//  memRvalid    in   1    read data valid; in order, one outstanding read max
//  memRdata     in   32   read data
// BEHAVIOUR
//  - Reset: FSM=IDLE, beat=0, all outputs 0, including dataBlock.
//    Reset mid-operation aborts immediately: memReq is 0 from the next cycle.
//  - Beat order: beat k maps to bits [32k+31:32k] and address offset 4k. Beat 0 first.
//  - IDLE: on missReq, latch missAddr (and victimAddr/victimBlock if victimValid).
//    Go to WB if victimValid, else RD_REQ.
//    memRvalid in IDLE is ignored (stale responses after reset).
//  - WB: memReq=1, memWe=1, memAddr={vAddr,beat,2'b00}, memWdata=vBlock[beat].
//    On memGnt: beat++.
//    When memGnt on beat 7: victimAck=1 next cycle, beat=0, go to RD_REQ.
//    memReq/addr/data are held stable until memGnt.
//  - RD_REQ: memReq=1, memWe=0, memAddr={mAddr,beat,2'b00}. On memGnt go to RD_WAIT.
//  - RD_WAIT: memReq=0. On memRvalid, write memRdata into dataBlock[beat].
//    If beat==7 go to DONE; else beat++ and go to RD_REQ.
//    memRvalid outside RD_WAIT is ignored.
//  - DONE: fillValid=1 for exactly 1 cycle, then IDLE.
//    dataBlock holds its value until the next fill writes it.
//  - Latency, zero-wait memory (gnt tied 1, rvalid one cycle after gnt):
//    - no victim: missReq to fillValid = 2*8+2 = 18 cycles;
//    - with victim: +8 cycles.
//  - Simultaneous events:
//    - missReq while busy is ignored; the requester holds missReq until fillValid.
//    - missReq high in the fillValid cycle starts a new fill only from the following IDLE cycle.
//  - memGnt without memReq has no effect.
//  - beat is a 3-bit counter; a wrap is impossible by construction, because exit happens at beat 7.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined:
//    - Cycle counter runs in RD_WAIT and clears on each memRvalid.
//    - On reaching TIMEOUT: fillErr=1 for 1 cycle, go to IDLE, no fillValid.
//    - Partial dataBlock is left as is.
//  MEM_TIMEOUT_EN undefined: no counter; RD_WAIT waits indefinitely; fillErr tied 0.
// TESTING
//  1. Clean miss, gnt=1, rvalid 1 cycle later, rdata=0x1000_000k for beat k:
//     - dataBlock[32k+:32]=0x1000_000k;
//     - fillValid at cycle 18;
//     - memAddr sequence {missAddr,k,00};
//     - no write beats.
//  2. Dirty victim, victimBlock beat k=0xA0+k, victimAddr=27'h0123:
//     - 8 write beats with memAddr 0x2460..0x247C;
//     - victimAck pulses once;
//     - then 8 reads; fillValid at cycle 26.
//  3. Back-pressure, memGnt low 3 cycles per beat:
//     - memReq/addr/wdata stay stable while waiting;
//     - no beat skipped or duplicated.
//  4. Second missReq asserted while busy, plus stray memRvalid in IDLE and WB:
//     - both are ignored; exactly one fillValid.
//  5. reset asserted in RD_WAIT after beat 3:
//     - next cycle all outputs are 0 and busy=0;
//     - a late memRvalid is ignored;
//     - a new miss completes normally.
//  6. MEM_TIMEOUT_EN, TIMEOUT=64, memRvalid withheld:
//     - fillErr pulse 64 cycles after the gnt;
//     - no fillValid; busy=0 the next cycle.

Source files
------------

// File: rtl/line_fill_engine.sv
`default_nettype none
// ============================================================================
// Module      : line_fill_engine
// Description : Memory-side miss engine. On a cache miss it first writes the
//               pending victim line (if any) back to memory, then reads the
//               missing line as single 32-bit beats, assembles it into
//               dataBlock and pulses fillValid.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, reset               clock (rising edge), synchronous active-high reset
//   missReq, missAddr        miss request and line address (sampled in IDLE)
//   victimValid/Addr/Block   victim line to write back before the refill
//   busy                     engine is not idle
//   victimAck                1-cycle pulse after the last victim beat is taken
//   fillValid, dataBlock     1-cycle pulse: dataBlock holds the complete line
//   fillErr                  1-cycle pulse: read timed out, fill aborted
//   memReq/We/Addr/Wdata     single-beat memory request channel
//   memGnt                   beat accepted when memReq & memGnt
//   memRvalid, memRdata      in-order read response, one outstanding read
// Configuration
//   MEM_TIMEOUT_EN  when defined, a stalled read aborts after TIMEOUT cycles
//                   in RD_WAIT; otherwise RD_WAIT waits forever, fillErr = 0.
// ============================================================================
module line_fill_engine #(
    parameter  int LINE_W     = 256,
    parameter  int BEAT_W     = 32,
    parameter  int TIMEOUT    = 64,
    localparam int BEATS      = LINE_W / BEAT_W,
    localparam int BEAT_IDX_W = $clog2(BEATS),
    localparam int OFF_W      = $clog2(BEAT_W / 8),
    localparam int LADDR_W    = 32 - BEAT_IDX_W - OFF_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               missReq,
    input  logic [LADDR_W-1:0] missAddr,
    input  logic               victimValid,
    input  logic [LADDR_W-1:0] victimAddr,
    input  logic [LINE_W-1:0]  victimBlock,
    output logic               busy,
    output logic               victimAck,
    output logic               fillValid,
    output logic [LINE_W-1:0]  dataBlock,
    output logic               fillErr,
    output logic               memReq,
    output logic               memWe,
    output logic [31:0]        memAddr,
    output logic [BEAT_W-1:0]  memWdata,
    input  logic               memGnt,
    input  logic               memRvalid,
    input  logic [BEAT_W-1:0]  memRdata
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WB      = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

    state_t                  state, state_next;
    logic [BEAT_IDX_W-1:0]   beat, beat_next;
    logic [LADDR_W-1:0]      miss_addr;
    logic [LADDR_W-1:0]      vict_addr;
    logic [LINE_W-1:0]       vict_block;
    logic [LINE_W-1:0]       data_block;
    logic                    victim_ack;

    logic                    mem_req;
    logic                    mem_we;
    logic [31:0]             mem_addr;
    logic [BEAT_W-1:0]       mem_wdata;
    logic                    fill_valid;
    logic                    fill_err;
    logic                    rd_beat_we;
    logic                    ack_set;

`ifdef MEM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Counts cycles spent waiting for the current read beat; any response
    // restarts the window so the limit applies per beat, not per line.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state != S_RD_WAIT || memRvalid) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            beat       <= '0;
            miss_addr  <= '0;
            vict_addr  <= '0;
            vict_block <= '0;
            data_block <= '0;
            victim_ack <= 1'b0;
        end else begin
            state      <= state_next;
            beat       <= beat_next;
            victim_ack <= ack_set;
            if (state == S_IDLE && missReq) begin
                miss_addr <= missAddr;
                if (victimValid) begin
                    vict_addr  <= victimAddr;
                    vict_block <= victimBlock;
                end
            end
            if (rd_beat_we) begin
                data_block[int'(beat)*BEAT_W +: BEAT_W] <= memRdata;
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        state_next = state;
        beat_next  = beat;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        fill_valid = 1'b0;
        fill_err   = 1'b0;
        rd_beat_we = 1'b0;
        ack_set    = 1'b0;

        case (state)
            S_IDLE: begin
                if (missReq) begin
                    beat_next  = '0;
                    state_next = victimValid ? S_WB : S_RD_REQ;
                end
            end

            S_WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {vict_addr, beat, OFF_W'(0)};
                mem_wdata = vict_block[int'(beat)*BEAT_W +: BEAT_W];
                if (memGnt) begin
                    if (beat == LAST_BEAT) begin
                        beat_next  = '0;
                        ack_set    = 1'b1;
                        state_next = S_RD_REQ;
                    end else begin
                        beat_next = beat + 1'b1;
                    end
                end
            end

            S_RD_REQ: begin
                mem_req  = 1'b1;
                mem_addr = {miss_addr, beat, OFF_W'(0)};
                if (memGnt) begin
                    state_next = S_RD_WAIT;
                end
            end

            S_RD_WAIT: begin
                if (memRvalid) begin
                    rd_beat_we = 1'b1;
                    if (beat == LAST_BEAT) begin
                        state_next = S_DONE;
                    end else begin
                        beat_next  = beat + 1'b1;
                        state_next = S_RD_REQ;
                    end
                end
`ifdef MEM_TIMEOUT_EN
                else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                    // Abort: partial dataBlock is left untouched.
                    fill_err   = 1'b1;
                    beat_next  = '0;
                    state_next = S_IDLE;
                end
`endif
            end

            S_DONE: begin
                fill_valid = 1'b1;
                beat_next  = '0;
                state_next = S_IDLE;
            end

            default: begin
                beat_next  = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign victimAck = victim_ack;
    assign fillValid = fill_valid;
    assign dataBlock = data_block;
    assign fillErr   = fill_err;
    assign memReq    = mem_req;
    assign memWe     = mem_we;
    assign memAddr   = mem_addr;
    assign memWdata  = mem_wdata;

endmodule

`default_nettype wire
